// File: rtl/step_sequencer.sv
// -----------------------------------------------------------------------------
// step_sequencer
//
// Turns one-cycle rate ticks into a bounded train of fixed-width STEP pulses
// for a stepper driver. A move is requested with `start`, which samples the
// direction and the step count. The direction is presented on `dir_out` for
// DIR_SETUP cycles before the first pulse can be issued. Each accepted tick
// then produces a PULSE_CYCLES-wide STEP pulse, and the remaining count is
// decremented. Ticks that arrive while a pulse cannot be issued are dropped
// and flagged on `overrun`.
//
// Parameters
//   CNT_W         width of step_count / remaining
//   PULSE_CYCLES  STEP high time in clk cycles (1..2^16-1)
//   DIR_SETUP     direction setup time in clk cycles (1..2^16-1)
//
// Ports
//   clk         system clock
//   rst         asynchronous reset, active low
//   tick        one-cycle rate pulse
//   start       one-cycle move request (ignored while busy)
//   dir_in      direction of the requested move, sampled with start
//   step_count  steps requested, sampled with start
//   abort       terminate the current move (ignored in IDLE)
//   step_out    STEP pulse to the driver
//   dir_out     registered direction to the driver
//   busy        move in progress
//   done        one-cycle pulse at the end of any move
//   remaining   steps not yet issued
//   overrun     one-cycle pulse when a tick is dropped
// -----------------------------------------------------------------------------
module step_sequencer #(
  parameter int CNT_W        = 16,
  parameter int PULSE_CYCLES = 100,
  parameter int DIR_SETUP    = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             start,
  input  logic             dir_in,
  input  logic [CNT_W-1:0] step_count,
  input  logic             abort,
  output logic             step_out,
  output logic             dir_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining,
  output logic             overrun
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_ARMED = 2'd2;
  localparam logic [1:0] S_HIGH  = 2'd3;

  // One shared down-counter times both the setup window and the pulse width.
  // It is loaded with N-1 so that the state lasts exactly N cycles: the exit
  // decision is taken in the cycle where the counter reads zero.
  localparam int TMR_W = 16;
  localparam logic [TMR_W-1:0] SETUP_LOAD = TMR_W'(DIR_SETUP - 1);
  localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(PULSE_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [TMR_W-1:0] tmr_q,   tmr_d;
  logic [CNT_W-1:0] rem_q,   rem_d;
  logic             dir_q,   dir_d;
  logic             step_q,  step_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic             ovr_q,   ovr_d;

  logic tmr_zero;
  logic rem_zero;

  assign tmr_zero = (tmr_q == '0);
  assign rem_zero = (rem_q == '0);

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    step_d  = step_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovr_d   = 1'b0;

    if (state_q == S_IDLE) begin
      // Ticks and abort are meaningless here; only a move request matters.
      if (start) begin
        if (step_count == '0) begin
          // Zero-length move completes immediately and leaves dir_out alone.
          done_d = 1'b1;
        end else begin
          rem_d   = step_count;
          dir_d   = dir_in;
          tmr_d   = SETUP_LOAD;
          busy_d  = 1'b1;
          state_d = S_SETUP;
        end
      end
    end else if (abort) begin
      // Abort wins over tick and over pulse completion in the same cycle.
      // The tick is not processed at all, so it is not reported as dropped.
      // remaining is left holding the count of steps never issued.
      step_d  = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      tmr_d   = '0;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_SETUP: begin
          ovr_d = tick;
          if (tmr_zero) begin
            state_d = S_ARMED;
          end else begin
            tmr_d = tmr_q - 1'b1;
          end
        end

        S_ARMED: begin
          // remaining is always >= 1 here, so the decrement cannot wrap.
          if (tick) begin
            step_d  = 1'b1;
            rem_d   = rem_q - 1'b1;
            tmr_d   = PULSE_LOAD;
            state_d = S_HIGH;
          end
        end

        S_HIGH: begin
          // Every HIGH cycle, including the last one, drops ticks.
          ovr_d = tick;
          if (tmr_zero) begin
            step_d = 1'b0;
            if (rem_zero) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end else begin
              state_d = S_ARMED;
            end
          end else begin
            tmr_d = tmr_q - 1'b1;
          end
        end

        default: begin
          state_d = S_IDLE;
          step_d  = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // Reset clears everything, including a STEP pulse in flight, without a
  // done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign step_out  = step_q;
  assign dir_out   = dir_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign remaining = rem_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_step_sequencer.sv
// -----------------------------------------------------------------------------
// tb_step_sequencer
//
// Directed vector table for the documented scenarios, a hand-written
// reset-mid-pulse sequence, and a randomized run. Every cycle the outputs are
// also compared with a timestamp-based reference model: a move is described
// by the edge from which ticks are accepted and the edge at which the current
// pulse falls.
// -----------------------------------------------------------------------------
module tb_step_sequencer;

  localparam int W = 16;
  localparam int P = 4;
  localparam int D = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         tick, start, dir_in, abort;
  logic [W-1:0] step_count;
  logic         step_out, dir_out, busy, done, overrun;
  logic [W-1:0] remaining;

  always #5 clk = ~clk;

  step_sequencer #(.CNT_W(W), .PULSE_CYCLES(P), .DIR_SETUP(D)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .dir_in(dir_in),
    .step_count(step_count), .abort(abort), .step_out(step_out),
    .dir_out(dir_out), .busy(busy), .done(done), .remaining(remaining),
    .overrun(overrun)
  );

  int checks = 0;
  int errors = 0;
  int ec     = 0;   // index of the clock edge about to be sampled

  // reference model state
  bit m_busy, m_dir, m_step, m_done, m_ovr;
  int m_rem, m_ready, m_fall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got %0d, expected %0d", name, ec, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_dir = 0; m_step = 0; m_done = 0; m_ovr = 0;
    m_rem = 0; m_ready = 0; m_fall = -1;
  endtask

  // Outputs expected after edge ec given the inputs sampled at that edge.
  task automatic model_edge(input bit s, input bit d, input int c, input bit t, input bit a);
    m_done = 0;
    m_ovr  = 0;
    if (!m_busy) begin
      if (s) begin
        if (c == 0) m_done = 1;
        else begin
          m_busy = 1; m_rem = c; m_dir = d;
          m_ready = ec + D + 1;   // first edge at which a tick is accepted
          m_fall  = -1;
        end
      end
    end else if (a) begin
      m_busy = 0; m_done = 1; m_step = 0; m_fall = -1;
    end else begin
      if (m_step && ec == m_fall) begin
        m_step = 0; m_fall = -1;
        if (m_rem == 0) begin m_busy = 0; m_done = 1; end
      end
      if (t) begin
        if (ec >= m_ready) begin
          m_step = 1; m_rem--; m_fall = ec + P; m_ready = ec + P + 1;
        end else m_ovr = 1;
      end
    end
  endtask

  task automatic cmp_model();
    chk("mdl_step",    step_out,  m_step);
    chk("mdl_dir",     dir_out,   m_dir);
    chk("mdl_busy",    busy,      m_busy);
    chk("mdl_done",    done,      m_done);
    chk("mdl_rem",     remaining, m_rem);
    chk("mdl_overrun", overrun,   m_ovr);
  endtask

  // Drive one cycle of inputs, advance the model, compare just after the edge.
  task automatic cyc(input bit s, input bit d, input int c, input bit t, input bit a);
    start = s; dir_in = d; step_count = W'(c); tick = t; abort = a;
    model_edge(s, d, c, t, a);
    @(posedge clk);
    ec++;
    #1;
    start = 0; dir_in = 0; step_count = '0; tick = 0; abort = 0;
    cmp_model();
  endtask

  typedef struct {
    int idle;
    bit s, d;
    int c;
    bit t, a;
    bit e_step, e_busy, e_done;
    int e_rem;
    bit e_ovr, e_dir;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int idle, bit s, bit d, int c, bit t, bit a,
                              bit es, bit eb, bit ed, int er, bit eo, bit edir);
    vec_t v;
    v = '{idle, s, d, c, t, a, es, eb, ed, er, eo, edir};
    return v;
  endfunction

  initial begin
    rst = 0; tick = 0; start = 0; dir_in = 0; step_count = '0; abort = 0;
    model_reset();

    //            idle s d c t a   step busy done rem ovr dir
    // 3-step move, ticks every 20 cycles, 4-cycle pulses
    tbl.push_back(mk( 2,1,1,3,0,0, 0,1,0,3,0,1));
    tbl.push_back(mk(19,0,0,0,1,0, 1,1,0,2,0,1));
    tbl.push_back(mk( 2,0,0,0,0,0, 1,1,0,2,0,1)); // 4th high cycle
    tbl.push_back(mk( 0,0,0,0,0,0, 0,1,0,2,0,1)); // fallen
    tbl.push_back(mk(15,0,0,0,1,0, 1,1,0,1,0,1));
    tbl.push_back(mk(19,0,0,0,1,0, 1,1,0,0,0,1));
    tbl.push_back(mk( 3,0,0,0,0,0, 0,0,1,0,0,1)); // done with falling edge
    tbl.push_back(mk( 0,0,0,0,0,0, 0,0,0,0,0,1));
    // zero-length move
    tbl.push_back(mk( 1,1,0,0,0,0, 0,0,1,0,0,1));
    tbl.push_back(mk( 0,0,0,0,0,0, 0,0,0,0,0,1));
    // overrun in SETUP and 2 cycles into a pulse
    tbl.push_back(mk( 1,1,0,2,0,0, 0,1,0,2,0,0));
    tbl.push_back(mk( 0,0,0,0,1,0, 0,1,0,2,1,0));
    tbl.push_back(mk( 0,0,0,0,0,0, 0,1,0,2,0,0));
    tbl.push_back(mk( 5,0,0,0,1,0, 1,1,0,1,0,0));
    tbl.push_back(mk( 1,0,0,0,1,0, 1,1,0,1,1,0));
    tbl.push_back(mk( 0,0,0,0,0,0, 1,1,0,1,0,0));
    tbl.push_back(mk( 0,0,0,0,0,0, 0,1,0,1,0,0));
    // tick in first ARMED cycle accepted; start while busy ignored
    tbl.push_back(mk( 0,1,1,9,1,0, 1,1,0,0,0,0));
    // tick in final HIGH cycle dropped
    tbl.push_back(mk( 2,0,0,0,1,0, 1,1,0,0,1,0));
    tbl.push_back(mk( 0,0,0,0,0,0, 0,0,1,0,0,0));
    // 5-step move aborted during 2nd pulse together with a tick
    tbl.push_back(mk( 1,1,1,5,0,0, 0,1,0,5,0,1));
    tbl.push_back(mk( 4,0,0,0,1,0, 1,1,0,4,0,1));
    tbl.push_back(mk( 5,0,0,0,1,0, 1,1,0,3,0,1));
    tbl.push_back(mk( 1,0,0,0,1,1, 0,0,1,3,0,1));
    tbl.push_back(mk( 0,0,0,0,1,0, 0,0,0,3,0,1));
    tbl.push_back(mk( 0,0,0,0,0,1, 0,0,0,3,0,1)); // abort in IDLE

    repeat (3) @(posedge clk);
    #1;
    rst = 1;
    chk("reset_step", step_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_rem",  remaining, 0);
    chk("reset_dir",  dir_out, 0);
    chk("reset_ovr",  overrun, 0);

    foreach (tbl[i]) begin
      repeat (tbl[i].idle) cyc(0, 0, 0, 0, 0);
      cyc(tbl[i].s, tbl[i].d, tbl[i].c, tbl[i].t, tbl[i].a);
      chk($sformatf("tbl%0d_step", i), step_out,  tbl[i].e_step);
      chk($sformatf("tbl%0d_busy", i), busy,      tbl[i].e_busy);
      chk($sformatf("tbl%0d_done", i), done,      tbl[i].e_done);
      chk($sformatf("tbl%0d_rem",  i), remaining, tbl[i].e_rem);
      chk($sformatf("tbl%0d_ovr",  i), overrun,   tbl[i].e_ovr);
      chk($sformatf("tbl%0d_dir",  i), dir_out,   tbl[i].e_dir);
    end

    // reset in the middle of a pulse
    cyc(1, 1, 2, 0, 0);
    repeat (4) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    chk("pre_rst_step", step_out, 1);
    #3;
    rst = 0;
    model_reset();
    #1;
    chk("rst_step", step_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rem",  remaining, 0);
    chk("rst_dir",  dir_out, 0);
    chk("rst_ovr",  overrun, 0);
    repeat (2) @(posedge clk);
    chk("rst_hold_done", done, 0);
    #1;
    rst = 1;
    // single-step move after reset, same as from cold
    cyc(1, 1, 1, 0, 0);
    chk("post_busy", busy, 1);
    chk("post_dir",  dir_out, 1);
    repeat (3) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    chk("post_step", step_out, 1);
    chk("post_rem",  remaining, 0);
    repeat (3) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("post_done", done, 1);
    chk("post_fall", step_out, 0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit s, d, t, a;
      int c;
      s = ($urandom_range(0, 20) == 0);
      d = 1'($urandom_range(0, 1));
      c = $urandom_range(0, 4);
      t = ($urandom_range(0, (i < 1500) ? 6 : 2) == 0);
      a = ($urandom_range(0, 70) == 0);
      cyc(s, d, c, t, a);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
